// File: rtl/fhe_cmd_dispatch_queue.sv
// fhe_cmd_dispatch_queue
//   In-order FIFO of {cmd,data0,data1} host words. Each word is issued to one
//   of NUM_CH execution channels. The channel comes from a host-programmed
//   route table indexed by command code.
// Ports
//   clk, rstn                   clock / async active-low reset
//   in_valid/in_ready/in_cmd/in_data0/in_data1   host command port
//   cfg_we/cfg_cmd/cfg_ch/cfg_en route table write (cfg_en=0 unmaps an entry)
//   out_valid[NUM_CH]           one-hot issue strobe; out_cmd/out_data0/1 shared
//   ch_ready[NUM_CH]            per-channel accept
//   count, busy                 occupancy, FSM not idle
//   err_unmapped                1-cycle pulse: a word with an unmapped cmd was dropped
//   err_timeout                 sticky head-stall timeout; cleared by flush or reset
module fhe_cmd_dispatch_queue #(
  parameter int FSIZE     = 64,
  parameter int CMD_W     = 8,
  parameter int DEPTH     = 16,
  parameter int NUM_CH    = 4,
  parameter int TIMEOUT   = 1023,
  parameter int CMD_FLUSH = 111
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CMD_W-1:0]          in_cmd,
  input  logic [FSIZE-1:0]          in_data0,
  input  logic [FSIZE-1:0]          in_data1,
  input  logic                      cfg_we,
  input  logic [CMD_W-1:0]          cfg_cmd,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic                      cfg_en,
  output logic [NUM_CH-1:0]         out_valid,
  input  logic [NUM_CH-1:0]         ch_ready,
  output logic [CMD_W-1:0]          out_cmd,
  output logic [FSIZE-1:0]          out_data0,
  output logic [FSIZE-1:0]          out_data1,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      busy,
  output logic                      err_unmapped,
  output logic                      err_timeout
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int NE   = 1 << CMD_W;
  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [FSIZE-1:0] d0;
    logic [FSIZE-1:0] d1;
    logic [CH_W-1:0]  ch;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FLUSH} state_t;

  state_t                   state, state_nxt;
  entry_t                   mem [DEPTH];
  entry_t                   head;
  logic [AW-1:0]            rd_ptr, wr_ptr;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic [NE-1:0]            rt_en;
  logic [NE-1:0][CH_W-1:0]  rt_ch;
  logic [TW-1:0]            stall, stall_nxt;
  logic                     hv, accept, flush, push, drop, pop, stalled;

  // Head is read straight from the registered storage, so a word written at
  // edge t is visible at t+1. Outputs are gated so they read 0 when empty.
  assign head      = mem[rd_ptr];
  assign hv        = (cnt != '0) && (state != S_FLUSH);
  assign out_cmd   = hv ? head.cmd : '0;
  assign out_data0 = hv ? head.d0  : '0;
  assign out_data1 = hv ? head.d1  : '0;
  assign count     = cnt;
  assign busy      = (state != S_IDLE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign out_valid[c] = hv && (head.ch == CH_W'(c));
  end

  assign pop     = |(out_valid & ch_ready);
  assign stalled = |(out_valid & ~ch_ready);
  assign accept  = in_valid && in_ready;
  assign flush   = accept && (in_cmd == CMD_W'(CMD_FLUSH));
  // Route lookup uses the table as of this cycle; a same-cycle cfg write
  // only affects later words.
  assign push    = accept && !flush &&  rt_en[in_cmd];
  assign drop    = accept && !flush && !rt_en[in_cmd];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (push) state_nxt = S_ISSUE;
      S_ISSUE: if (pop && !push && cnt == CW'(1)) state_nxt = S_IDLE;
      S_FLUSH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_FLUSH;
  end

  always_comb begin
    cnt_nxt = flush ? '0 : cnt + CW'(push) - CW'(pop);
    stall_nxt = stall;
    if (flush || pop)                           stall_nxt = '0;
    else if (stalled && stall != TW'(TIMEOUT))  stall_nxt = stall + TW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      cnt          <= '0;
      in_ready     <= 1'b1;
      stall        <= '0;
      err_timeout  <= 1'b0;
      err_unmapped <= 1'b0;
      rt_en        <= '0;
      rt_ch        <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      stall        <= stall_nxt;
      err_unmapped <= drop;
      // Registered so ch_ready never reaches in_ready combinationally.
      in_ready     <= (cnt_nxt != CW'(DEPTH)) && (state_nxt != S_FLUSH);
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
      end
      if (flush)
        err_timeout <= 1'b0;
      else if (TIMEOUT != 0 && stall_nxt == TW'(TIMEOUT) && stalled)
        err_timeout <= 1'b1;
      if (cfg_we) begin
        rt_en[cfg_cmd] <= cfg_en;
        rt_ch[cfg_cmd] <= cfg_ch;
      end
    end
  end

  // Payload storage needs no reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cmd: in_cmd, d0: in_data0, d1: in_data1, ch: rt_ch[in_cmd]};
  end

endmodule

// File: tb/tb_fhe_cmd_dispatch_queue.sv
// Directed bench for fhe_cmd_dispatch_queue (TIMEOUT overridden to 8).
module tb_fhe_cmd_dispatch_queue;
  localparam int FSIZE = 64, CMD_W = 8, DEPTH = 16, NUM_CH = 4;

  logic             clk = 1'b0, rstn = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic [CMD_W-1:0] in_cmd = '0;
  logic [FSIZE-1:0] in_data0 = '0, in_data1 = '0;
  logic             cfg_we = 1'b0, cfg_en = 1'b0;
  logic [CMD_W-1:0] cfg_cmd = '0;
  logic [1:0]       cfg_ch = '0;
  logic [NUM_CH-1:0] out_valid, ch_ready = '0;
  logic [CMD_W-1:0] out_cmd;
  logic [FSIZE-1:0] out_data0, out_data1;
  logic [4:0]       count;
  logic             busy, err_unmapped, err_timeout;

  int checks = 0, failures = 0;

  fhe_cmd_dispatch_queue #(.FSIZE(FSIZE), .CMD_W(CMD_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH),
                           .TIMEOUT(8), .CMD_FLUSH(111)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_data0(in_data0), .in_data1(in_data1), .cfg_we(cfg_we), .cfg_cmd(cfg_cmd),
    .cfg_ch(cfg_ch), .cfg_en(cfg_en), .out_valid(out_valid), .ch_ready(ch_ready),
    .out_cmd(out_cmd), .out_data0(out_data0), .out_data1(out_data1), .count(count),
    .busy(busy), .err_unmapped(err_unmapped), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [7:0] c, input logic [1:0] ch);
    cfg_we = 1'b1; cfg_cmd = c; cfg_ch = ch; cfg_en = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic push(input logic [7:0] c, input logic [63:0] d0, input logic [63:0] d1);
    in_valid = 1'b1; in_cmd = c; in_data0 = d0; in_data1 = d1;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_unmapped", 64'(err_unmapped), 64'd0);
    chk("rst_err_timeout", 64'(err_timeout), 64'd0);
    rstn = 1'b1;
    step();
    cfg(8'd41, 2'd1);
    cfg(8'd66, 2'd2);

    // 1: back-to-back issue to two channels
    ch_ready = 4'hF;
    push(8'd41, 64'd1, 64'h11); step();
    chk("t1_ov0", 64'(out_valid), 64'h2);
    chk("t1_cmd0", 64'(out_cmd), 64'd41);
    chk("t1_d0_0", out_data0, 64'd1);
    chk("t1_d1_0", out_data1, 64'h11);
    chk("t1_busy", 64'(busy), 64'd1);
    push(8'd66, 64'd2, 64'h22); step();
    chk("t1_ov1", 64'(out_valid), 64'h4);
    chk("t1_d0_1", out_data0, 64'd2);
    chk("t1_count_pushpop", 64'(count), 64'd1);
    push(8'd41, 64'd3, 64'h33); step();
    chk("t1_ov2", 64'(out_valid), 64'h2);
    chk("t1_d0_2", out_data0, 64'd3);
    in_valid = 1'b0; step();
    chk("t1_ov_end", 64'(out_valid), 64'h0);
    chk("t1_count_end", 64'(count), 64'd0);
    chk("t1_busy_end", 64'(busy), 64'd0);

    // 2: fill to full with all channels stalled, then drain in order
    ch_ready = 4'h0;
    for (int i = 0; i < 16; i++) begin
      push(i[0] ? 8'd66 : 8'd41, 64'(100 + i), 64'(3 * i));
      step();
    end
    chk("t2_count_full", 64'(count), 64'd16);
    chk("t2_in_ready_full", 64'(in_ready), 64'd0);
    push(8'd41, 64'd999, 64'd0); step();
    chk("t2_17th_rejected", 64'(count), 64'd16);
    in_valid = 1'b0;
    ch_ready = 4'hF;
    for (int i = 0; i < 16; i++) begin
      if (i == 1) chk("t2_in_ready_rise", 64'(in_ready), 64'd1);
      chk($sformatf("t2_d0_%0d", i), out_data0, 64'(100 + i));
      chk($sformatf("t2_ov_%0d", i), 64'(out_valid), i[0] ? 64'h4 : 64'h2);
      step();
    end
    chk("t2_count_drained", 64'(count), 64'd0);
    chk("t2_in_ready_end", 64'(in_ready), 64'd1);
    chk("t2_err_timeout_set", 64'(err_timeout), 64'd1);

    // 3: unmapped command dropped
    push(8'd99, 64'd5, 64'd5); step();
    in_valid = 1'b0;
    chk("t3_err_unmapped", 64'(err_unmapped), 64'd1);
    chk("t3_count", 64'(count), 64'd0);
    chk("t3_ov", 64'(out_valid), 64'h0);
    step();
    chk("t3_err_unmapped_pulse", 64'(err_unmapped), 64'd0);

    // 4: flush with 5 words queued
    ch_ready = 4'h0;
    for (int i = 0; i < 5; i++) begin
      push(8'd41, 64'(200 + i), 64'd0);
      step();
    end
    chk("t4_count5", 64'(count), 64'd5);
    push(8'd111, 64'd0, 64'd0); step();
    in_valid = 1'b0;
    chk("t4_flush_busy", 64'(busy), 64'd1);
    chk("t4_flush_count", 64'(count), 64'd0);
    chk("t4_flush_ov", 64'(out_valid), 64'h0);
    chk("t4_flush_in_ready", 64'(in_ready), 64'd0);
    chk("t4_flush_err_timeout", 64'(err_timeout), 64'd0);
    step();
    chk("t4_idle_busy", 64'(busy), 64'd0);
    chk("t4_idle_in_ready", 64'(in_ready), 64'd1);
    chk("t4_idle_ov", 64'(out_valid), 64'h0);

    // 5: head stall timeout at 8 cycles, head held then issued
    push(8'd66, 64'hABC, 64'hDEF); step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("t5_err_before", 64'(err_timeout), 64'd0);
    step();
    chk("t5_err_at8", 64'(err_timeout), 64'd1);
    chk("t5_held_ov", 64'(out_valid), 64'h4);
    chk("t5_held_d0", out_data0, 64'hABC);
    step();
    chk("t5_still_held", 64'(out_valid), 64'h4);
    ch_ready = 4'b0100; step();
    chk("t5_issued_ov", 64'(out_valid), 64'h0);
    chk("t5_issued_count", 64'(count), 64'd0);
    chk("t5_err_sticky", 64'(err_timeout), 64'd1);

    // 6: async reset mid-drain clears queue and route table
    ch_ready = 4'h0;
    for (int i = 0; i < 3; i++) begin
      push(8'd41, 64'(300 + i), 64'd0);
      step();
    end
    in_valid = 1'b0;
    ch_ready = 4'hF; step();
    chk("t6_count_mid", 64'(count), 64'd2);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_ov", 64'(out_valid), 64'h0);
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
    chk("t6_rst_err_timeout", 64'(err_timeout), 64'd0);
    step();
    rstn = 1'b1;
    step();
    push(8'd41, 64'd7, 64'd7); step();
    in_valid = 1'b0;
    chk("t6_unmapped_after_rst", 64'(err_unmapped), 64'd1);
    chk("t6_count_after_rst", 64'(count), 64'd0);
    chk("t6_ov_after_rst", 64'(out_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
